// File: rtl/mon_c2sif.sv
// mon_c2sif: samples one DUT output and answers level/history/edge-count
// reads and edge-count clears over a c2sif req/ack handshake.
module mon_c2sif #(
    parameter int unsigned ID      = 0,
    parameter int unsigned HIST_W  = 32,
    parameter bit          SYNC_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dout,
    input  logic        req,
    input  logic [7:0]  req_id,
    input  logic [7:0]  req_fn,
    output logic        ack,
    output logic [31:0] rsp_data,
    output logic [7:0]  rsp_ret
);
    typedef enum logic [1:0] {IDLE, RESP, SKIP} state_t;

    state_t              state, state_n;
    logic                s1, s2, s, s_q, req_q, rise, clr, known;
    logic [HIST_W-1:0]   hist;
    logic [HIST_W:0]     hist_n;
    logic [31:0]         edge_cnt, data_n, rd;
    logic [7:0]          ret_n;
    logic                ack_n;

    assign s      = SYNC_EN ? s2 : s1;
    assign hist_n = {hist, s};
    assign rise   = req & ~req_q;
    assign known  = req_fn >= 8'd1 && req_fn <= 8'd4;
    assign rd     = req_fn == 8'd1 ? {31'b0, s} :
                    req_fn == 8'd2 ? 32'(hist) :
                    known ? edge_cnt : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= SKIP;
            s1       <= 1'b0;
            s2       <= 1'b0;
            s_q      <= 1'b0;
            req_q    <= 1'b0;
            hist     <= '0;
            edge_cnt <= 32'd0;
            ack      <= 1'b0;
            rsp_data <= 32'd0;
            rsp_ret  <= 8'd0;
        end else begin
            state    <= state_n;
            s1       <= dout;
            s2       <= s1;
            s_q      <= s;
            req_q    <= req;
            hist     <= hist_n[HIST_W-1:0];
            ack      <= ack_n;
            rsp_data <= data_n;
            rsp_ret  <= ret_n;
            // a clear on the same edge as a rising sample drops that edge
            if (clr)
                edge_cnt <= 32'd0;
            else if (s && !s_q)
                edge_cnt <= edge_cnt + 32'd1;
        end
    end

    always_comb begin
        state_n = state;
        ack_n   = ack;
        data_n  = rsp_data;
        ret_n   = rsp_ret;
        clr     = 1'b0;
        if (state == IDLE && rise) begin
            if (req_id == 8'(ID)) begin
                state_n = RESP;
                ack_n   = 1'b1;
                data_n  = rd;
                ret_n   = known ? 8'd0 : 8'd1;
                clr     = req_fn == 8'd4;
            end else begin
                state_n = SKIP;
            end
        end else if (state == RESP && !req) begin
            state_n = IDLE;
            ack_n   = 1'b0;
            data_n  = 32'd0;
            ret_n   = 8'd0;
        end else if (state == SKIP && !req) begin
            state_n = IDLE;
        end
    end
endmodule
